traffic_countdown_display: RTL and testbench



---
 rtl/traffic_countdown_display.sv | 180 ++++++++++++++++++
 tb/tb_traffic_countdown_display.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_countdown_display.sv
// Per-road countdown to the next lamp change on a 4-digit multiplexed 7-segment display, with a sticky lamp/count fault.
// Optional feature: define TCD_LEADING_ZERO_BLANK_EN to blank a zero tens digit while counting down.
module traffic_countdown_display #(
   parameter int T1       = 25,
   parameter int T2       = 30,
   parameter int T3       = 55,
   parameter int PERIOD   = 60,
   parameter int SCAN_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] count,
   input  logic [2:0] light1,
   input  logic [2:0] light2,
   output logic [6:0] seg_n,
   output logic [3:0] dig_n,
   output logic       fault
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      FAULT
   } state_t;

   state_t state;
   state_t state_next;

   logic [6:0]       count_ext;
   logic             lamps_valid;
   logic [6:0]       rem1;
   logic [6:0]       rem2;
   logic [3:0]       rem1_tens;
   logic [3:0]       rem1_ones;
   logic [3:0]       rem2_tens;
   logic [3:0]       rem2_ones;
   logic [DIV_W-1:0] scan_div;
   logic [1:0]       scan_idx;
   logic [3:0]       digit_val;
   logic             digit_is_tens;
   logic [6:0]       seg_next;

   function automatic logic one_hot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   function automatic logic [6:0] decode_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h01;
         4'd1:    s = 7'h4F;
         4'd2:    s = 7'h12;
         4'd3:    s = 7'h06;
         4'd4:    s = 7'h4C;
         4'd5:    s = 7'h24;
         4'd6:    s = 7'h20;
         4'd7:    s = 7'h0F;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h04;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   assign count_ext   = {1'b0, count};
   assign lamps_valid = one_hot3(light1) && one_hot3(light2) &&
                        (light1[2] ^ light2[2]) && (count_ext < 7'(PERIOD));

   // Seconds until each road's lamp next changes; rem2 counts across the wrap to T1.
   always_comb begin
      rem1 = 7'(PERIOD) - count_ext;
      if (count_ext < 7'(T1))
         rem1 = 7'(T1) - count_ext;
      else if (count_ext < 7'(T3))
         rem1 = 7'(T3) - count_ext;

      rem2 = 7'(PERIOD + T1) - count_ext;
      if (count_ext < 7'(T1))
         rem2 = 7'(T1) - count_ext;
      else if (count_ext < 7'(T2))
         rem2 = 7'(T2) - count_ext;
      else if (count_ext < 7'(T3))
         rem2 = 7'(T3) - count_ext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem1_tens <= 4'd0;
         rem1_ones <= 4'd0;
         rem2_tens <= 4'd0;
         rem2_ones <= 4'd0;
      end else begin
         rem1_tens <= 4'(rem1 / 7'd10);
         rem1_ones <= 4'(rem1 % 7'd10);
         rem2_tens <= 4'(rem2 / 7'd10);
         rem2_ones <= 4'(rem2 % 7'd10);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= INIT;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         INIT:    if (lamps_valid) state_next = RUN;
         RUN:     if (!lamps_valid) state_next = FAULT;
         FAULT:   state_next = FAULT;
         default: state_next = INIT;
      endcase
   end

   always_comb begin
      fault         = (state == FAULT);
      digit_val     = rem2_ones;
      digit_is_tens = 1'b0;
      case (scan_idx)
         2'd3: begin
            digit_val     = rem1_tens;
            digit_is_tens = 1'b1;
         end
         2'd2: digit_val = rem1_ones;
         2'd1: begin
            digit_val     = rem2_tens;
            digit_is_tens = 1'b1;
         end
         default: digit_val = rem2_ones;
      endcase

      seg_next = SEG_BLANK;
      case (state)
         RUN: begin
`ifdef TCD_LEADING_ZERO_BLANK_EN
            if (digit_is_tens && (digit_val == 4'd0))
               seg_next = SEG_BLANK;
            else
               seg_next = decode_digit(digit_val);
`else
            seg_next = decode_digit(digit_val);
`endif
         end
         FAULT:   seg_next = SEG_DASH;
         default: seg_next = SEG_BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_div <= '0;
         scan_idx <= 2'd0;
      end else if (scan_div == DIV_MAX) begin
         scan_div <= '0;
         scan_idx <= scan_idx + 2'd1;
      end else begin
         scan_div <= scan_div + DIV_W'(1);
      end
   end

   // Segments and enables come from the same index in one register stage, so they never skew.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_n <= SEG_BLANK;
         dig_n <= 4'hE;
      end else begin
         seg_n <= seg_next;
         dig_n <= ~(4'b0001 << scan_idx);
      end
   end

endmodule

// File: tb/tb_traffic_countdown_display.sv
// Self-checking bench for traffic_countdown_display: randomized legal counts against a rule-level countdown model.
module tb_traffic_countdown_display;

   localparam int T1       = 25;
   localparam int T2       = 30;
   localparam int T3       = 55;
   localparam int PERIOD   = 60;
   localparam int SCAN_DIV = 4;

   localparam int MODE_INIT  = 0;
   localparam int MODE_RUN   = 1;
   localparam int MODE_FAULT = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] count;
   logic [2:0] light1;
   logic [2:0] light2;
   logic [6:0] seg_n;
   logic [3:0] dig_n;
   logic       fault;

   int pass_cnt  = 0;
   int total_cnt = 0;

   traffic_countdown_display #(
      .T1(T1), .T2(T2), .T3(T3), .PERIOD(PERIOD), .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .count(count),
      .light1(light1),
      .light2(light2),
      .seg_n(seg_n),
      .dig_n(dig_n),
      .fault(fault)
   );

   always #5 clk = ~clk;

   function automatic int rem1_of(input int c);
      if (c < T1) return T1 - c;
      if (c < T3) return T3 - c;
      return PERIOD - c;
   endfunction

   function automatic int rem2_of(input int c);
      if (c < T1) return T1 - c;
      if (c < T2) return T2 - c;
      if (c < T3) return T3 - c;
      return PERIOD + T1 - c;
   endfunction

   function automatic logic [6:0] lit_segments(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   // Expected segment pattern for a display position (3 = road 1 tens ... 0 = road 2 ones).
   function automatic logic [6:0] exp_seg(input int mode, input int pos, input int c);
      int rem;
      int d;
      if (mode == MODE_INIT) return 7'h7F;
      if (mode == MODE_FAULT) return 7'b1111110;
      rem = (pos >= 2) ? rem1_of(c) : rem2_of(c);
      d   = (pos % 2 == 1) ? rem / 10 : rem % 10;
`ifdef TCD_LEADING_ZERO_BLANK_EN
      if ((pos % 2 == 1) && (d == 0)) return 7'h7F;
`endif
      return ~lit_segments(d);
   endfunction

   function automatic int pos_of(input logic [3:0] dn);
      case (dn)
         4'hE: return 0;
         4'hD: return 1;
         4'hB: return 2;
         4'h7: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic rand_legal(output logic [2:0] l1, output logic [2:0] l2);
      logic [2:0] moving;
      moving = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b010;
      if ($urandom_range(0, 1) == 1) begin
         l1 = 3'b100;
         l2 = moving;
      end else begin
         l1 = moving;
         l2 = 3'b100;
      end
   endtask

   task automatic set_inputs(input int c, input logic [2:0] l1, input logic [2:0] l2);
      @(negedge clk);
      count  = 6'(c);
      light1 = l1;
      light2 = l2;
   endtask

   task automatic assert_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Waits out the two-edge latency, then samples a full scan cycle.
   task automatic check_display(input string name, input int mode, input int c);
      int pos;
      logic [6:0] exp;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 4 * SCAN_DIV; i++) begin
         @(negedge clk);
         pos = pos_of(dig_n);
         total_cnt++;
         if (pos < 0) begin
            $display("[TB] FAIL %s dig_n: got %h, required one-hot-low", name, dig_n);
         end else begin
            exp = exp_seg(mode, pos, c);
            if (seg_n !== exp)
               $display("[TB] FAIL %s seg_n pos %0d count %0d: got %b, required %b",
                        name, pos, c, seg_n, exp);
            else
               pass_cnt++;
         end
         total_cnt++;
         if (fault !== (mode == MODE_FAULT))
            $display("[TB] FAIL %s fault: got %b, required %b", name, fault, mode == MODE_FAULT);
         else
            pass_cnt++;
      end
   endtask

   task automatic test_reset();
      count  = 6'd0;
      light1 = 3'b000;
      light2 = 3'b000;
      assert_reset();
      total_cnt++;
      if ({seg_n, dig_n, fault} !== {7'h7F, 4'hE, 1'b0})
         $display("[TB] FAIL reset outputs: got seg %h dig %h fault %b, required 7f e 0",
                  seg_n, dig_n, fault);
      else
         pass_cnt++;
      release_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total_cnt++;
         if (seg_n !== 7'h7F || fault !== 1'b0)
            $display("[TB] FAIL init blank: got seg %h fault %b, required 7f 0", seg_n, fault);
         else
            pass_cnt++;
      end
   endtask

   task automatic test_init_invalid();
      set_inputs(PERIOD, 3'b010, 3'b100);
      check_display("init_count_oob", MODE_INIT, PERIOD);
      set_inputs(PERIOD - 1, 3'b001, 3'b100);
      check_display("enter_run", MODE_RUN, PERIOD - 1);
   endtask

   task automatic test_directed();
      set_inputs(0, 3'b010, 3'b100);
      check_display("count0", MODE_RUN, 0);
      set_inputs(T1, 3'b100, 3'b001);
      check_display("countT1", MODE_RUN, T1);
      set_inputs(T3, 3'b001, 3'b100);
      check_display("countT3", MODE_RUN, T3);
   endtask

   task automatic test_wrap();
      int pos;
      logic [6:0] exp;
      set_inputs(PERIOD - 1, 3'b001, 3'b100);
      check_display("count_last", MODE_RUN, PERIOD - 1);
      set_inputs(0, 3'b010, 3'b100);
      for (int i = 0; i < 2 * SCAN_DIV; i++) begin
         @(negedge clk);
         pos = pos_of(dig_n);
         exp = exp_seg(MODE_RUN, (pos < 0) ? 0 : pos, (i == 0) ? PERIOD - 1 : 0);
         total_cnt++;
         if (pos < 0 || seg_n !== exp)
            $display("[TB] FAIL wrap cycle %0d: got seg %b dig %h, required seg %b",
                     i, seg_n, dig_n, exp);
         else
            pass_cnt++;
      end
   endtask

   task automatic test_random();
      int c;
      logic [2:0] l1;
      logic [2:0] l2;
      for (int n = 0; n < 20; n++) begin
         c = $urandom_range(0, PERIOD - 1);
         rand_legal(l1, l2);
         set_inputs(c, l1, l2);
         check_display("random", MODE_RUN, c);
      end
   endtask

   task automatic test_scan_timing();
      logic [3:0] prev;
      int run_len;
      bit first_run;
      @(negedge clk);
      prev      = dig_n;
      run_len   = 1;
      first_run = 1'b1;
      for (int i = 0; i < 10 * SCAN_DIV; i++) begin
         @(negedge clk);
         if (dig_n === prev) begin
            run_len++;
         end else begin
            total_cnt++;
            if (dig_n !== {prev[2:0], prev[3]})
               $display("[TB] FAIL scan order: got %h after %h, required %h",
                        dig_n, prev, {prev[2:0], prev[3]});
            else
               pass_cnt++;
            if (!first_run) begin
               total_cnt++;
               if (run_len != SCAN_DIV)
                  $display("[TB] FAIL scan hold %h: got %0d cycles, required %0d",
                           prev, run_len, SCAN_DIV);
               else
                  pass_cnt++;
            end
            first_run = 1'b0;
            prev      = dig_n;
            run_len   = 1;
         end
      end
   endtask

   task automatic test_fault_count();
      set_inputs(PERIOD, 3'b100, 3'b010);
      @(posedge clk);
      #1;
      total_cnt++;
      if (fault !== 1'b1)
         $display("[TB] FAIL fault_count: got fault %b, required 1", fault);
      else
         pass_cnt++;
      check_display("fault_count_dash", MODE_FAULT, PERIOD);
      assert_reset();
      total_cnt++;
      if (fault !== 1'b0 || seg_n !== 7'h7F)
         $display("[TB] FAIL fault_clear: got fault %b seg %h, required 0 7f", fault, seg_n);
      else
         pass_cnt++;
      count  = 6'd10;
      light1 = 3'b010;
      light2 = 3'b100;
      release_reset();
      check_display("rerun", MODE_RUN, 10);
   endtask

   task automatic test_fault_no_red();
      set_inputs(12, 3'b001, 3'b001);
      @(posedge clk);
      #1;
      total_cnt++;
      if (fault !== 1'b1)
         $display("[TB] FAIL fault_no_red: got fault %b, required 1", fault);
      else
         pass_cnt++;
      check_display("no_red_dash", MODE_FAULT, 12);
      set_inputs(12, 3'b010, 3'b100);
      check_display("fault_sticky", MODE_FAULT, 12);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      light1 = 3'b000;
      light2 = 3'b000;
      assert_reset();
      total_cnt++;
      if ({seg_n, dig_n, fault} !== {7'h7F, 4'hE, 1'b0})
         $display("[TB] FAIL reset_mid_scan: got seg %h dig %h fault %b, required 7f e 0",
                  seg_n, dig_n, fault);
      else
         pass_cnt++;
      release_reset();
      for (int i = 0; i <= SCAN_DIV; i++) begin
         @(negedge clk);
         total_cnt++;
         if (dig_n !== ((i < SCAN_DIV) ? 4'hE : 4'hD) || seg_n !== 7'h7F)
            $display("[TB] FAIL scan_restart cycle %0d: got dig %h seg %h, required %h 7f",
                     i, dig_n, seg_n, (i < SCAN_DIV) ? 4'hE : 4'hD);
         else
            pass_cnt++;
      end
   endtask

   initial begin
      rst_n  = 1'b1;
      count  = 6'd0;
      light1 = 3'b000;
      light2 = 3'b000;
      test_reset();
      test_init_invalid();
      test_directed();
      test_wrap();
      test_random();
      test_scan_timing();
      test_fault_count();
      test_fault_no_red();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
